// File: rtl/sr_bank_pkg.sv
// Shared definitions for the SR flop bank: S=R=1 resolution modes and the
// per-channel next-state function used by every storage cell.
package sr_bank_pkg;

  typedef enum logic [1:0] {
    SR_MODE_RST_DOM = 2'd0,  // S=R=1 clears the channel
    SR_MODE_SET_DOM = 2'd1,  // S=R=1 sets the channel
    SR_MODE_HOLD    = 2'd2,  // S=R=1 keeps the current value
    SR_MODE_TOGGLE  = 2'd3   // S=R=1 inverts the current value
  } sr_mode_e;

  // Next stored value of one enabled channel given its set/reset requests.
  function automatic logic sr_next(input sr_mode_e mode, input logic q,
                                   input logic s, input logic r);
    logic nq;
    nq = q;
    case ({s, r})
      2'b10:   nq = 1'b1;
      2'b01:   nq = 1'b0;
      2'b11: begin
        case (mode)
          SR_MODE_RST_DOM: nq = 1'b0;
          SR_MODE_SET_DOM: nq = 1'b1;
          SR_MODE_HOLD:    nq = q;
          SR_MODE_TOGGLE:  nq = ~q;
          default:         nq = q;
        endcase
      end
      default: nq = q;
    endcase
    return nq;
  endfunction

endpackage

// File: rtl/sr_cell.sv
// One SR storage channel: a single state flop driving Qa and its complement,
// a registered change strobe and a combinational "enabled conflict" flag for
// the shared flag/counter logic in the top.
// Optional build macro SR_BANK_EDGE_DET_EN: requests become 0->1 transitions
// of S and R instead of levels.
module sr_cell
  import sr_bank_pkg::*;
#(
  parameter int MODE = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic s,
  input  logic r,
  input  logic en,
  output logic qa,
  output logic qb,
  output logic changed,
  output logic hit
);

  localparam sr_mode_e CELL_MODE = sr_mode_e'(MODE[1:0]);

  logic q;
  logic q_next;
  logic s_req;
  logic r_req;

`ifdef SR_BANK_EDGE_DET_EN
  logic s_prev;
  logic r_prev;

  // Track last-cycle S/R every cycle, independent of enable, so a level held
  // across a disabled stretch is not mistaken for a new request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_prev <= 1'b0;
      r_prev <= 1'b0;
    end else begin
      s_prev <= s;
      r_prev <= r;
    end
  end

  assign s_req = s & ~s_prev;
  assign r_req = r & ~r_prev;
`else
  assign s_req = s;
  assign r_req = r;
`endif

  // Next state: hold when disabled, otherwise resolve the requests.
  always_comb begin
    q_next = q;
    if (en) q_next = sr_next(CELL_MODE, q, s_req, r_req);
  end

  assign hit = en & s_req & r_req;

  // State flop and change strobe; reset acts without a clock edge.
  // NOTE: sequential state uses non-blocking assignments so every flop in the
  // bank samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q       <= 1'b0;
      changed <= 1'b0;
    end else begin
      q       <= q_next;
      changed <= q_next ^ q;
    end
  end

  // Qb is derived from the same flop, so Qa and Qb can never agree.
  assign qa = q;
  assign qb = ~q;

endmodule

// File: rtl/sr_flop_bank.sv
// WIDTH-channel clocked SR flag bank with selectable S=R=1 resolution,
// per-channel change strobes, sticky conflict flags and a saturating count
// of cycles in which any enabled channel saw a conflict.
// Optional build macro SR_BANK_EDGE_DET_EN selects edge-triggered requests
// (handled inside each sr_cell).
module sr_flop_bank
  import sr_bank_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int MODE  = 0,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] S,
  input  logic [WIDTH-1:0] R,
  input  logic [WIDTH-1:0] Enable,
  input  logic             clr_conflict,
  output logic [WIDTH-1:0] Qa,
  output logic [WIDTH-1:0] Qb,
  output logic [WIDTH-1:0] changed,
  output logic [WIDTH-1:0] conflict,
  output logic [CNT_W-1:0] conflict_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [WIDTH-1:0] hit;
  logic             any_hit;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    sr_cell #(
      .MODE(MODE)
    ) u_cell (
      .clk    (clk),
      .rst    (rst),
      .s      (S[i]),
      .r      (R[i]),
      .en     (Enable[i]),
      .qa     (Qa[i]),
      .qb     (Qb[i]),
      .changed(changed[i]),
      .hit    (hit[i])
    );
  end

  // At most one count per cycle however many channels conflict.
  assign any_hit = |hit;

  // Sticky conflict flags; a conflict in the clearing cycle wins over the clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      conflict <= '0;
    end else if (clr_conflict) begin
      conflict <= hit;
    end else begin
      conflict <= conflict | hit;
    end
  end

  // Saturating conflict-cycle counter; clear reloads 1 if this cycle conflicts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      conflict_cnt <= '0;
    end else if (clr_conflict) begin
      conflict_cnt <= any_hit ? CNT_ONE : '0;
    end else if (any_hit && conflict_cnt != CNT_MAX) begin
      conflict_cnt <= conflict_cnt + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_sr_flop_bank.sv
// Directed self-checking bench for sr_flop_bank. Four instances cover the
// resolution modes: reset-dominant, toggle, set-dominant with a 2-bit counter,
// and hold. Expected values are hand-computed constants.
`timescale 1ns/1ps
module tb_sr_flop_bank;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // MODE 0 instance
  logic [7:0] s0, r0, e0, qa0, qb0, ch0, cf0, cnt0;
  logic       clr0;
  // MODE 3 instance
  logic [7:0] s3, r3, e3, qa3, qb3, ch3, cf3, cnt3;
  logic       clr3;
  // MODE 1, CNT_W=2 instance
  logic [7:0] s1, r1, e1, qa1, qb1, ch1, cf1;
  logic [1:0] cnt1;
  logic       clr1;
  // MODE 2 instance
  logic [7:0] s2, r2, e2, qa2, qb2, ch2, cf2, cnt2;
  logic       clr2;

  int n_checks = 0;
  int n_fail   = 0;

  sr_flop_bank #(.WIDTH(8), .MODE(0), .CNT_W(8)) u_dut0 (
    .clk(clk), .rst(rst), .S(s0), .R(r0), .Enable(e0), .clr_conflict(clr0),
    .Qa(qa0), .Qb(qb0), .changed(ch0), .conflict(cf0), .conflict_cnt(cnt0));

  sr_flop_bank #(.WIDTH(8), .MODE(3), .CNT_W(8)) u_dut3 (
    .clk(clk), .rst(rst), .S(s3), .R(r3), .Enable(e3), .clr_conflict(clr3),
    .Qa(qa3), .Qb(qb3), .changed(ch3), .conflict(cf3), .conflict_cnt(cnt3));

  sr_flop_bank #(.WIDTH(8), .MODE(1), .CNT_W(2)) u_dut1 (
    .clk(clk), .rst(rst), .S(s1), .R(r1), .Enable(e1), .clr_conflict(clr1),
    .Qa(qa1), .Qb(qb1), .changed(ch1), .conflict(cf1), .conflict_cnt(cnt1));

  sr_flop_bank #(.WIDTH(8), .MODE(2), .CNT_W(8)) u_dut2 (
    .clk(clk), .rst(rst), .S(s2), .R(r2), .Enable(e2), .clr_conflict(clr2),
    .Qa(qa2), .Qb(qb2), .changed(ch2), .conflict(cf2), .conflict_cnt(cnt2));

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h", tag, got, exp);
    end
  endtask

  // Advance one edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    {s0, r0, e0, clr0} = '0;
    {s3, r3, e3, clr3} = '0;
    {s1, r1, e1, clr1} = '0;
    {s2, r2, e2, clr2} = '0;
    repeat (2) tick();

    check("rst_qa",   32'(qa0),  'h00);
    check("rst_qb",   32'(qb0),  'hFF);
    check("rst_chg",  32'(ch0),  'h00);
    check("rst_cf",   32'(cf0),  'h00);
    check("rst_cnt",  32'(cnt0), 'h00);
    rst = 1'b0;

`ifndef SR_BANK_EDGE_DET_EN
    // Set, repeat set, reset on channel 0.
    s0 = 8'h01; e0 = 8'h01;
    tick();
    check("set_qa",  32'(qa0), 'h01);
    check("set_qb",  32'(qb0), 'hFE);
    check("set_chg", 32'(ch0), 'h01);
    tick();
    check("reset_repeat_qa",  32'(qa0), 'h01);
    check("reset_repeat_chg", 32'(ch0), 'h00);
    s0 = 8'h00; r0 = 8'h01;
    tick();
    check("clr_qa",  32'(qa0), 'h00);
    check("clr_chg", 32'(ch0), 'h01);

    // Enable gating: requests ignored for 5 edges.
    s0 = 8'hFF; r0 = 8'hFF; e0 = 8'h00;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("gate_qa",  32'(qa0), 'h00);
      check("gate_chg", 32'(ch0), 'h00);
      check("gate_cf",  32'(cf0), 'h00);
    end
    check("gate_cnt", 32'(cnt0), 'h00);

    // Reset-dominant conflict on channel 2 from Qa[2]=1.
    s0 = 8'h04; r0 = 8'h00; e0 = 8'h04;
    tick();
    check("m0_pre_qa", 32'(qa0), 'h04);
    r0 = 8'h04;
    for (int i = 1; i <= 3; i++) begin
      tick();
      check("m0_qa",  32'(qa0),  'h00);
      check("m0_chg", 32'(ch0),  (i == 1) ? 'h04 : 'h00);
      check("m0_cnt", 32'(cnt0), i);
    end
    check("m0_cf", 32'(cf0), 'h04);
    s0 = 8'h00; r0 = 8'h00; e0 = 8'h00;

    // Toggle mode on channel 2 from Qa[2]=0.
    s3 = 8'h04; r3 = 8'h04; e3 = 8'h04;
    for (int i = 1; i <= 3; i++) begin
      tick();
      check("m3_qa",  32'(qa3),  (i % 2 == 1) ? 'h04 : 'h00);
      check("m3_qb",  32'(qb3),  (i % 2 == 1) ? 'hFB : 'hFF);
      check("m3_chg", 32'(ch3),  'h04);
      check("m3_cnt", 32'(cnt3), i);
    end
    check("m3_cf", 32'(cf3), 'h04);
    s3 = 8'h00; r3 = 8'h00; e3 = 8'h00;

    // Set-dominant, 2-bit counter: two channels conflict per cycle.
    s1 = 8'h12; r1 = 8'h12; e1 = 8'h12;
    for (int i = 1; i <= 5; i++) begin
      tick();
      check("m1_qa",  32'(qa1),  'h12);
      check("m1_cnt", 32'(cnt1), (i > 3) ? 3 : i);
    end
    check("m1_cf", 32'(cf1), 'h12);
    check("m1_qb", 32'(qb1), 'hED);
    s1 = 8'h02; r1 = 8'h02; e1 = 8'h02; clr1 = 1'b1;
    tick();
    check("m1_clrhit_cnt", 32'(cnt1), 'h1);
    check("m1_clrhit_cf",  32'(cf1),  'h02);
    check("m1_clrhit_chg", 32'(ch1),  'h00);
    s1 = 8'h00; r1 = 8'h00; e1 = 8'h00;
    tick();
    check("m1_clr_cnt", 32'(cnt1), 'h0);
    check("m1_clr_cf",  32'(cf1),  'h00);
    clr1 = 1'b0;

    // Hold mode on channels 5 and 6.
    s2 = 8'h20; e2 = 8'h20;
    tick();
    check("m2_set_qa", 32'(qa2), 'h20);
    r2 = 8'h20;
    tick();
    check("m2_qa",  32'(qa2),  'h20);
    check("m2_chg", 32'(ch2),  'h00);
    check("m2_cf",  32'(cf2),  'h20);
    check("m2_cnt", 32'(cnt2), 'h01);
    s2 = 8'h40; r2 = 8'h40; e2 = 8'h40;
    tick();
    check("m2b_qa",  32'(qa2),  'h20);
    check("m2b_qb",  32'(qb2),  'hDF);
    check("m2b_cf",  32'(cf2),  'h60);
    check("m2b_cnt", 32'(cnt2), 'h02);
    s2 = 8'h00; r2 = 8'h00; e2 = 8'h00;

    // Clear without simultaneous conflict, then a fresh conflict and load A5.
    clr0 = 1'b1;
    tick();
    check("m0_clr_cf",  32'(cf0),  'h00);
    check("m0_clr_cnt", 32'(cnt0), 'h00);
    clr0 = 1'b0;
    s0 = 8'h08; r0 = 8'h08; e0 = 8'h08;
    tick();
    check("m0_hit_cf",  32'(cf0),  'h08);
    check("m0_hit_cnt", 32'(cnt0), 'h01);
    s0 = 8'hA5; r0 = 8'h5A; e0 = 8'hFF;
    tick();
    check("load_qa",  32'(qa0),  'hA5);
    check("load_chg", 32'(ch0),  'hA5);
    check("load_cnt", 32'(cnt0), 'h01);
    e0 = 8'h00;
    tick();
    check("load_hold_qa", 32'(qa0), 'hA5);
`else
    // Edge-detect: held S acts once; each new rising S sets again.
    s0 = 8'h01; e0 = 8'h01;
    tick();
    check("ed_set_qa", 32'(qa0), 'h01);
    s0 = 8'h00; r0 = 8'h01;
    tick();
    check("ed_rst_qa", 32'(qa0), 'h00);
    r0 = 8'h00; s0 = 8'h01;
    for (int i = 1; i <= 4; i++) begin
      tick();
      check("ed_hold_qa",  32'(qa0), 'h01);
      check("ed_hold_chg", 32'(ch0), (i == 1) ? 'h01 : 'h00);
    end
    s0 = 8'h00; r0 = 8'h01;
    tick();
    check("ed_pulse_r_qa", 32'(qa0), 'h00);
    r0 = 8'h00; s0 = 8'h01;
    tick();
    check("ed_reset_qa", 32'(qa0), 'h01);
    // Held conflict counts only on the rising cycle.
    s0 = 8'h06; r0 = 8'h06; e0 = 8'h06;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("ed_cnt", 32'(cnt0), 'h01);
    end
    check("ed_cf", 32'(cf0), 'h06);
    check("ed_qa", 32'(qa0), 'h01);
    check("ed_other", 32'({qb1, qb2, qb3, ch1}), 'hFFFFFF00);
`endif

    // Async reset between edges with a pending set on every channel.
    s0 = 8'hFF; r0 = 8'h00; e0 = 8'hFF;
    #2 rst = 1'b1;
    #1;
    check("async_qa",  32'(qa0),  'h00);
    check("async_qb",  32'(qb0),  'hFF);
    check("async_cnt", 32'(cnt0), 'h00);
    check("async_cf",  32'(cf0),  'h00);
    check("async_chg", 32'(ch0),  'h00);
    tick();
    check("rst_hold_qa", 32'(qa0), 'h00);
    #2 rst = 1'b0;
    tick();
    check("post_rst_qa",  32'(qa0), 'hFF);
    check("post_rst_chg", 32'(ch0), 'hFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
